bcd_digit_sequencer: RTL and testbench

Consumes a multi-digit BCD value from the seconds/event counters and presents it one digit at a time on the single 7-segment display. Digits appear most-significant first, each for a programmable dwell time followed by a blank gap, with the decimal point marking the last digit. The block sits between the counter stages and the io_out[7:0] pins. It owns all display timing and the load handshake.

---
 rtl/bcd_digit_sequencer_pkg.sv | 27 ++
 rtl/bcd_digit_sequencer_seg_decode.sv | 17 +
 rtl/bcd_digit_sequencer.sv | 158 +++++++++++++++
 tb/tb_bcd_digit_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_digit_sequencer_pkg.sv
// Shared display definitions: sequencer states and 7-segment patterns.
package bcd_digit_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    GAP
  } state_t;

  // Segment order is bit0=a ... bit6=g, active-high.
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;

  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'b0111111,  // 0
    7'b0000110,  // 1
    7'b1011011,  // 2
    7'b1001111,  // 3
    7'b1100110,  // 4
    7'b1101101,  // 5
    7'b1111101,  // 6
    7'b0000111,  // 7
    7'b1111111,  // 8
    7'b1101111   // 9
  };

endpackage

// File: rtl/bcd_digit_sequencer_seg_decode.sv
// Combinational BCD nibble to 7-segment decoder; non-decimal nibbles show a dash.
module bcd_seg_decode
  import bcd_digit_sequencer_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_segments
);

  // Table lookup for 0-9, dash for 10-15.
  always_comb begin
    o_segments = SEG_DASH;
    if (i_nibble <= 4'd9) begin
      o_segments = SEG_DIGIT[i_nibble];
    end
  end

endmodule

// File: rtl/bcd_digit_sequencer.sv
// Presents a captured multi-digit BCD value one digit at a time on a single
// 7-segment display, most-significant first, with dwell/gap timing.
module bcd_digit_sequencer
  import bcd_digit_sequencer_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 500,
  parameter int GAP_CYCLES   = 100
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      value_valid,
  output logic                      value_ready,
  input  logic [4*NUM_DIGITS-1:0]   value_bcd,
  input  logic                      lz_suppress,
  output logic [6:0]                segments,
  output logic                      dp,
  output logic                      busy
);

  localparam int CNT_MAX = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] TOP_IDX    = IDX_W'(NUM_DIGITS - 1);

  state_t                    r_state;
  state_t                    w_next_state;
  logic [IDX_W-1:0]          r_idx;
  logic [IDX_W-1:0]          w_next_idx;
  logic [CNT_W-1:0]          r_cnt;
  logic [CNT_W-1:0]          w_next_cnt;
  logic [4*NUM_DIGITS-1:0]   r_value;
  logic [4*NUM_DIGITS-1:0]   w_next_value;
  logic [IDX_W-1:0]          w_start_idx;
  logic [3:0]                w_nibble;
  logic [6:0]                w_dec_seg;
  logic                      w_accept;
  logic [6:0]                r_segments;
  logic                      r_dp;
  logic                      r_busy;

  assign value_ready = (r_state == IDLE) && !reset;
  assign w_accept    = value_valid && value_ready;
  assign segments    = r_segments;
  assign dp          = r_dp;
  assign busy        = r_busy;

  // Leading-zero priority encoder: highest nonzero nibble wins, all-zero starts at 0.
  always_comb begin
    w_start_idx = TOP_IDX;
    if (lz_suppress) begin
      w_start_idx = '0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (value_bcd[4*i +: 4] != 4'd0) begin
          w_start_idx = IDX_W'(i);
        end
      end
    end
  end

  // Next-state, digit index, cycle counter and capture logic.
  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    w_next_cnt   = r_cnt;
    w_next_value = r_value;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = SHOW;
          w_next_idx   = w_start_idx;
          w_next_cnt   = '0;
          w_next_value = value_bcd;
        end
      end
      SHOW: begin
        if (r_cnt == DWELL_LAST) begin
          w_next_cnt = '0;
          if (GAP_CYCLES > 0) begin
            w_next_state = GAP;
          end else if (r_idx != '0) begin
            w_next_idx = r_idx - 1'b1;
          end else begin
            w_next_state = IDLE;
          end
        end else begin
          w_next_cnt = r_cnt + 1'b1;
        end
      end
      GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_next_cnt = '0;
          if (r_idx != '0) begin
            w_next_state = SHOW;
            w_next_idx   = r_idx - 1'b1;
          end else begin
            w_next_state = IDLE;
          end
        end else begin
          w_next_cnt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_next_cnt   = '0;
        w_next_idx   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state, so the nibble to decode is
  // selected from the value/index that will be current after this edge.
  always_comb begin
    w_nibble = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (IDX_W'(i) == w_next_idx) begin
        w_nibble = w_next_value[4*i +: 4];
      end
    end
  end

  bcd_seg_decode u_decode (
    .i_nibble   (w_nibble),
    .o_segments (w_dec_seg)
  );

  // FSM state, index, counter and captured value registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_value <= '0;
    end else begin
      r_state <= w_next_state;
      r_idx   <= w_next_idx;
      r_cnt   <= w_next_cnt;
      r_value <= w_next_value;
    end
  end

  // Registered display outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_segments <= SEG_BLANK;
      r_dp       <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_segments <= (w_next_state == SHOW) ? w_dec_seg : SEG_BLANK;
      r_dp       <= (w_next_state == SHOW) && (w_next_idx == '0);
      r_busy     <= (w_next_state != IDLE);
    end
  end

endmodule

// File: tb/tb_bcd_digit_sequencer.sv
// Self-checking bench: table vectors, hand-written corner sequences and random
// values, compared cycle by cycle against a digit-list display model.
module tb_bcd_digit_sequencer;

  localparam int ND = 4;
  localparam int DW = 4;
  localparam int GP = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        valid_a, ready_a, lz_a, dp_a, busy_a;
  logic [15:0] bcd_a;
  logic [6:0]  seg_a;
  logic        valid_b, ready_b, lz_b, dp_b, busy_b;
  logic [15:0] bcd_b;
  logic [6:0]  seg_b;

  bcd_digit_sequencer #(.NUM_DIGITS(ND), .DWELL_CYCLES(DW), .GAP_CYCLES(GP)) u_dut_a (
    .clk(clk), .reset(reset), .value_valid(valid_a), .value_ready(ready_a),
    .value_bcd(bcd_a), .lz_suppress(lz_a), .segments(seg_a), .dp(dp_a), .busy(busy_a)
  );

  bcd_digit_sequencer #(.NUM_DIGITS(ND), .DWELL_CYCLES(DW), .GAP_CYCLES(0)) u_dut_b (
    .clk(clk), .reset(reset), .value_valid(valid_b), .value_ready(ready_b),
    .value_bcd(bcd_b), .lz_suppress(lz_b), .segments(seg_b), .dp(dp_b), .busy(busy_b)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] value;
    logic        lz;
    int          sel;
    int          exp_busy;
    logic [6:0]  exp_first;
  } vec_t;

  vec_t tbl [8];
  logic [7:0] exp_q [$];  // {dp, segments} per displayed cycle

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0111111;
      4'd1: return 7'b0000110;
      4'd2: return 7'b1011011;
      4'd3: return 7'b1001111;
      4'd4: return 7'b1100110;
      4'd5: return 7'b1101101;
      4'd6: return 7'b1111101;
      4'd7: return 7'b0000111;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1101111;
      default: return 7'b1000000;
    endcase
  endfunction

  // Model: strip leading zero characters (keeping one), then each digit is
  // lit for DW cycles followed by gap blank cycles; the last digit carries dp.
  task automatic build_trace(input logic [15:0] v, input logic lz, input int gap);
    int n;
    logic [3:0] d;
    exp_q.delete();
    n = ND;
    if (lz) begin
      while (n > 1 && 4'(v >> (4*(n-1))) == 4'd0) n--;
    end
    for (int i = n - 1; i >= 0; i--) begin
      d = 4'(v >> (4*i));
      repeat (DW) exp_q.push_back({(i == 0) ? 1'b1 : 1'b0, ref_seg(d)});
      repeat (gap) exp_q.push_back(8'h00);
    end
  endtask

  function automatic logic [9:0] obs(input int sel);
    if (sel != 0) return {ready_b, busy_b, dp_b, seg_b};
    return {ready_a, busy_a, dp_a, seg_a};
  endfunction

  task automatic drive(input int sel, input logic vld, input logic [15:0] v, input logic lz);
    if (sel != 0) begin
      valid_b = vld; bcd_b = v; lz_b = lz;
    end else begin
      valid_a = vld; bcd_a = v; lz_a = lz;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_seq(input int sel, input logic [15:0] v, input logic lz, input bit hold,
                         output int busy_cycles, output logic [6:0] first_seg, output int blanks);
    logic [9:0] o;
    build_trace(v, lz, (sel != 0) ? 0 : GP);
    o = obs(sel);
    check($sformatf("ready_before sel%0d v=%h", sel, v), 32'(o[9]), 32'd1);
    drive(sel, 1'b1, v, lz);
    tick();
    if (hold) drive(sel, 1'b1, 16'h5555, 1'b0);
    else      drive(sel, 1'b0, 16'($urandom), 1'($urandom));
    busy_cycles = 0;
    blanks = 0;
    first_seg = obs(sel) & 10'h07f;
    for (int i = 0; i < exp_q.size(); i++) begin
      o = obs(sel);
      check($sformatf("cyc%0d sel%0d v=%h {rdy,busy,dp,seg}", i, sel, v),
            32'(o), 32'({1'b0, 1'b1, exp_q[i]}));
      if (o[8]) busy_cycles++;
      if (o[8] && o[6:0] == 7'd0) blanks++;
      tick();
    end
    o = obs(sel);
    check($sformatf("end sel%0d v=%h {rdy,busy,dp,seg}", sel, v), 32'(o), 32'(10'h200));
  endtask

  initial begin
    int bc, bl;
    logic [6:0] fs;
    logic [15:0] rv;
    logic [9:0] o;

    tbl[0] = '{16'h1234, 1'b0, 0, 24, 7'b0000110};
    tbl[1] = '{16'h0070, 1'b1, 0, 12, 7'b0000111};
    tbl[2] = '{16'h0000, 1'b1, 0, 6,  7'b0111111};
    tbl[3] = '{16'h00A9, 1'b1, 0, 12, 7'b1000000};
    tbl[4] = '{16'h0070, 1'b0, 0, 24, 7'b0111111};
    tbl[5] = '{16'hF000, 1'b1, 0, 24, 7'b1000000};
    tbl[6] = '{16'h1234, 1'b0, 1, 16, 7'b0000110};
    tbl[7] = '{16'h0009, 1'b1, 1, 4,  7'b1101111};

    reset = 1'b1;
    drive(0, 1'b0, 16'h0, 1'b0);
    drive(1, 1'b0, 16'h0, 1'b0);
    repeat (3) tick();
    check("reset_a {rdy,busy,dp,seg}", 32'(obs(0)), 32'd0);
    check("reset_b {rdy,busy,dp,seg}", 32'(obs(1)), 32'd0);
    reset = 1'b0;
    #1;
    check("ready_after_init_reset", 32'(ready_a), 32'd1);
    tick();

    for (int t = 0; t < 8; t++) begin
      run_seq(tbl[t].sel, tbl[t].value, tbl[t].lz, 1'b0, bc, fs, bl);
      check($sformatf("vec%0d busy_cycles", t), 32'(bc), 32'(tbl[t].exp_busy));
      check($sformatf("vec%0d first_seg", t), 32'(fs), 32'(tbl[t].exp_first));
      if (tbl[t].sel != 0) check($sformatf("vec%0d no_blank_between_digits", t), 32'(bl), 32'd0);
      tick();
    end

    // Valid held with a new value during a sequence, then back-to-back accept.
    run_seq(0, 16'h1234, 1'b0, 1'b1, bc, fs, bl);
    run_seq(0, 16'h5555, 1'b0, 1'b0, bc, fs, bl);
    check("b2b second busy_cycles", 32'(bc), 32'd24);
    tick();

    // Reset during the third SHOW cycle of digit index 2.
    build_trace(16'h1234, 1'b0, GP);
    drive(0, 1'b1, 16'h1234, 1'b0);
    tick();
    drive(0, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i <= 8; i++) begin
      o = obs(0);
      check($sformatf("rst_seq cyc%0d", i), 32'(o), 32'({1'b0, 1'b1, exp_q[i]}));
      if (i < 8) tick();
    end
    reset = 1'b1;
    tick();
    check("mid_reset {rdy,busy,dp,seg}", 32'(obs(0)), 32'd0);
    reset = 1'b0;
    #1;
    check("ready_after_mid_reset", 32'(ready_a), 32'd1);
    tick();
    check("idle_after_mid_reset", 32'(obs(0)), 32'(10'h200));

    // Random values, biased toward zero nibbles to exercise suppression.
    for (int r = 0; r < 30; r++) begin
      for (int k = 0; k < 4; k++) begin
        rv[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      end
      run_seq(int'($urandom_range(0, 1)), rv, 1'($urandom_range(0, 1)), 1'b0, bc, fs, bl);
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
